// File: rtl/qos_pkg.sv
// Shared definitions for the QoS virtual-channel to destination scheduler.
// State encodings, error-bit positions and the destination-bit helper.
package qos_pkg;

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    typedef enum logic [4:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

    localparam int ERR_VC0 = 0;
    localparam int ERR_VC1 = 1;
    localparam int ERR_D0  = 2;
    localparam int ERR_D1  = 3;

    // Destination select is carried in the top bit of every data word.
    function automatic int dest_idx(input int bw);
        return bw - 1;
    endfunction

endpackage

// File: rtl/qos_vc_arbiter.sv
// VC0-priority arbiter with a weighted starvation guard for VC1.
// One grant per cycle at most; counter tracks consecutive VC0 wins.
module qos_vc_arbiter #(
    parameter int WEIGHT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vc0_empty_i,
    input  logic vc1_empty_i,
    input  logic allow_i,
    input  logic enable_i,
    output logic grant0_o,
    output logic grant1_o
);

    localparam logic [3:0] WMAX = 4'(WEIGHT);

    logic [3:0] cnt_q, cnt_d;
    logic       go;
    logic       starve;

    assign go     = allow_i & enable_i;
    assign starve = (cnt_q >= WMAX) & ~vc1_empty_i;

    assign grant0_o = go & ~vc0_empty_i & ~starve;
    assign grant1_o = go & ~vc1_empty_i & (vc0_empty_i | starve);

    always_comb begin
        cnt_d = cnt_q;
        if (vc1_empty_i || grant1_o) begin
            cnt_d = '0;
        end else if (grant0_o && (cnt_q < WMAX)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qos_vc_dest_scheduler.sv
// Moves words from VC0/VC1 into D0/D1 with weighted priority and backpressure.
// Also sequences threshold programming and reports FSM status.
module qos_vc_dest_scheduler
    import qos_pkg::*;
#(
    parameter int BW     = 6,
    parameter int LEN    = 4,
    parameter int WEIGHT = 4
) (
    input  logic           clk,
    input  logic           reset_L,
    input  logic           init,
    input  logic [LEN-1:0] Umbral_LOW_in,
    input  logic [LEN-1:0] Umbral_HIGH_in,
    input  logic           VC0_empty,
    input  logic           VC1_empty,
    input  logic [BW-1:0]  VC0_data,
    input  logic [BW-1:0]  VC1_data,
    output logic           VC0_rd,
    output logic           VC1_rd,
    input  logic           D0_almost_full,
    input  logic           D1_almost_full,
    input  logic [3:0]     fifo_error,
    output logic           D0_wr,
    output logic           D1_wr,
    output logic [BW-1:0]  D_data_out,
    output logic [LEN-1:0] UmbralD_LOW_cond,
    output logic [LEN-1:0] UmbralD_HIGH_cond,
    output logic [4:0]     state,
    output logic           idle_out,
    output logic           active_out,
    output logic           error_out
);

    localparam int DST = dest_idx(BW);

    state_e         state_q, state_d;
    logic           pend_q;
    logic           src_q;
    logic [BW-1:0]  dout_q;
    logic [LEN-1:0] low_q, high_q;

    logic           any_err;
    logic           vc_busy;
    logic           g0, g1;
    logic           arb_en, arb_allow;
    logic [BW-1:0]  sel_data;

    assign any_err = |fifo_error;
    assign vc_busy = ~VC0_empty | ~VC1_empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT: begin
                if (any_err)    state_d = S_ERROR;
                else if (!init) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (any_err)      state_d = S_ERROR;
                else if (init)    state_d = S_INIT;
                else if (vc_busy) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (any_err)                   state_d = S_ERROR;
                else if (init)                 state_d = S_INIT;
                else if (!vc_busy && !pend_q)  state_d = S_IDLE;
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
    end

    // Destination is unknown until the word is read, so either almost-full blocks.
    assign arb_en    = (state_q == S_ACTIVE) & ~init;
    assign arb_allow = ~D0_almost_full & ~D1_almost_full;

    qos_vc_arbiter #(
        .WEIGHT (WEIGHT)
    ) u_arb (
        .clk         (clk),
        .rst_n       (reset_L),
        .vc0_empty_i (VC0_empty),
        .vc1_empty_i (VC1_empty),
        .allow_i     (arb_allow),
        .enable_i    (arb_en),
        .grant0_o    (g0),
        .grant1_o    (g1)
    );

    assign VC0_rd = g0;
    assign VC1_rd = g1;

    assign sel_data   = src_q ? VC1_data : VC0_data;
    assign D0_wr      = pend_q & ~sel_data[DST];
    assign D1_wr      = pend_q &  sel_data[DST];
    assign D_data_out = pend_q ? sel_data : dout_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_RESET;
            pend_q  <= 1'b0;
            src_q   <= 1'b0;
            dout_q  <= '0;
            low_q   <= '0;
            high_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= g0 | g1;
            src_q   <= g1;
            if (pend_q) begin
                dout_q <= sel_data;
            end
            if (state_q == S_INIT) begin
                low_q  <= Umbral_LOW_in;
                high_q <= Umbral_HIGH_in;
            end
        end
    end

    assign UmbralD_LOW_cond  = low_q;
    assign UmbralD_HIGH_cond = high_q;
    assign state             = state_q;
    assign idle_out          = (state_q == S_IDLE);
    assign active_out        = (state_q == S_ACTIVE);
    assign error_out         = (state_q == S_ERROR);

endmodule

// File: tb/tb_qos_vc_dest_scheduler.sv
// Scoreboard bench for qos_vc_dest_scheduler with a queue-based reference model.
// Source FIFOs are modelled as queues; expected writes are checked by a monitor.
module tb_qos_vc_dest_scheduler;

    localparam int BW     = 6;
    localparam int LEN    = 4;
    localparam int WEIGHT = 4;

    logic           clk = 1'b0;
    logic           reset_L;
    logic           init;
    logic [LEN-1:0] Umbral_LOW_in, Umbral_HIGH_in;
    logic           VC0_empty, VC1_empty;
    logic [BW-1:0]  VC0_data, VC1_data;
    logic           VC0_rd, VC1_rd;
    logic           D0_almost_full, D1_almost_full;
    logic [3:0]     fifo_error;
    logic           D0_wr, D1_wr;
    logic [BW-1:0]  D_data_out;
    logic [LEN-1:0] UmbralD_LOW_cond, UmbralD_HIGH_cond;
    logic [4:0]     state;
    logic           idle_out, active_out, error_out;

    always #5 clk = ~clk;

    qos_vc_dest_scheduler #(
        .BW (BW), .LEN (LEN), .WEIGHT (WEIGHT)
    ) dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .init              (init),
        .Umbral_LOW_in     (Umbral_LOW_in),
        .Umbral_HIGH_in    (Umbral_HIGH_in),
        .VC0_empty         (VC0_empty),
        .VC1_empty         (VC1_empty),
        .VC0_data          (VC0_data),
        .VC1_data          (VC1_data),
        .VC0_rd            (VC0_rd),
        .VC1_rd            (VC1_rd),
        .D0_almost_full    (D0_almost_full),
        .D1_almost_full    (D1_almost_full),
        .fifo_error        (fifo_error),
        .D0_wr             (D0_wr),
        .D1_wr             (D1_wr),
        .D_data_out        (D_data_out),
        .UmbralD_LOW_cond  (UmbralD_LOW_cond),
        .UmbralD_HIGH_cond (UmbralD_HIGH_cond),
        .state             (state),
        .idle_out          (idle_out),
        .active_out        (active_out),
        .error_out         (error_out)
    );

    typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mst_e;

    int total = 0;
    int bad   = 0;

    mst_e           ms = M_RESET;
    int             streak = 0;
    bit             mpend = 1'b0;
    logic [LEN-1:0] mlow = '0, mhigh = '0;
    logic [BW-1:0]  vc0_q[$], vc1_q[$], sb[$];
    bit             glog_en = 1'b0;
    bit             glog[$];
    logic [BW-1:0]  last_d = '0;
    logic [BW-1:0]  mw;

    function automatic logic [4:0] onehot(input mst_e s);
        case (s)
            M_RESET:  return 5'b00001;
            M_INIT:   return 5'b00010;
            M_IDLE:   return 5'b00100;
            M_ACTIVE: return 5'b01000;
            default:  return 5'b10000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd_empty();
        VC0_empty = (vc0_q.size() == 0);
        VC1_empty = (vc1_q.size() == 0);
    endtask

    // One clock of the reference model: check at negedge, advance, apply pops.
    task automatic cycle();
        bit ne0, ne1, allow, e0, e1, p0, p1;
        logic [BW-1:0] w0, w1;
        mst_e nx;
        p0 = 1'b0; p1 = 1'b0; w0 = '0; w1 = '0;
        @(negedge clk);
        if (!reset_L) begin
            ms = M_RESET; mpend = 1'b0; streak = 0; mlow = '0; mhigh = '0;
        end
        chk("state", {27'b0, state}, {27'b0, onehot(ms)});
        chk("status", {29'b0, error_out, active_out, idle_out},
            {29'b0, ms == M_ERROR, ms == M_ACTIVE, ms == M_IDLE});
        chk("thr", {24'b0, UmbralD_LOW_cond, UmbralD_HIGH_cond}, {24'b0, mlow, mhigh});
        ne0   = vc0_q.size() != 0;
        ne1   = vc1_q.size() != 0;
        allow = (ms == M_ACTIVE) && !init && !D0_almost_full && !D1_almost_full;
        e0    = allow && ne0 && !(streak >= WEIGHT && ne1);
        e1    = allow && !e0 && ne1;
        chk("rd", {30'b0, VC0_rd, VC1_rd}, {30'b0, e0, e1});
        if (glog_en && (VC0_rd || VC1_rd)) glog.push_back(VC1_rd);
        if (ms == M_INIT) begin
            mlow  = Umbral_LOW_in;
            mhigh = Umbral_HIGH_in;
        end
        nx = ms;
        if (!reset_L)                  nx = M_RESET;
        else if (ms == M_RESET)        nx = M_INIT;
        else if (|fifo_error)          nx = M_ERROR;
        else if (ms == M_INIT)         nx = init ? M_INIT : M_IDLE;
        else if (ms == M_IDLE)         nx = init ? M_INIT : ((ne0 || ne1) ? M_ACTIVE : M_IDLE);
        else if (ms == M_ACTIVE)       nx = init ? M_INIT : ((!ne0 && !ne1 && !mpend) ? M_IDLE : M_ACTIVE);
        if (!ne1 || e1)               streak = 0;
        else if (e0 && streak < WEIGHT) streak++;
        if (e0) begin w0 = vc0_q.pop_front(); sb.push_back(w0); p0 = 1'b1; end
        if (e1) begin w1 = vc1_q.pop_front(); sb.push_back(w1); p1 = 1'b1; end
        mpend = e0 || e1;
        ms    = nx;
        @(posedge clk);
        #1;
        if (p0) VC0_data = w0;
        if (p1) VC1_data = w1;
        upd_empty();
    endtask

    always @(negedge clk) begin
        if (!reset_L) begin
            sb.delete();
            last_d = '0;
        end else if (D0_wr || D1_wr) begin
            chk("wr_excl", {31'b0, D0_wr & D1_wr}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexp: got write %0h want none", D_data_out);
            end else begin
                mw = sb.pop_front();
                chk("wdata", {26'b0, D_data_out}, {26'b0, mw});
                chk("wdest", {30'b0, D1_wr, D0_wr}, mw[BW-1] ? 32'd2 : 32'd1);
                last_d = mw;
            end
        end else begin
            chk("hold", {26'b0, D_data_out}, {26'b0, last_d});
        end
    end

    initial begin
        reset_L = 1'b0; init = 1'b0;
        Umbral_LOW_in = '0; Umbral_HIGH_in = '0;
        VC0_data = '0; VC1_data = '0;
        D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        fifo_error = '0;
        upd_empty();

        repeat (2) cycle();
        chk("rst_out", {21'b0, VC0_rd, VC1_rd, D0_wr, D1_wr, D_data_out}, 32'd0);

        reset_L = 1'b1; init = 1'b1;
        Umbral_LOW_in = 4'd1; Umbral_HIGH_in = 4'd3;
        repeat (2) cycle();
        init = 1'b0;
        cycle();
        Umbral_LOW_in = 4'd9; Umbral_HIGH_in = 4'd12;
        repeat (2) cycle();
        chk("thr_hold", {24'b0, UmbralD_LOW_cond, UmbralD_HIGH_cond}, 32'h13);

        vc0_q.push_back(6'h05); vc0_q.push_back(6'h21); upd_empty();
        repeat (6) cycle();
        chk("idle_after", {27'b0, state}, 32'b00100);

        for (int i = 0; i < 25; i++) begin
            vc0_q.push_back(6'($urandom_range(0, 63)));
            vc1_q.push_back(6'($urandom_range(0, 63)));
        end
        upd_empty();
        glog_en = 1'b1;
        repeat (14) cycle();
        glog_en = 1'b0;
        chk("glog_n", {31'b0, glog.size() >= 10}, 32'd1);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            chk("grant_pat", {31'b0, glog[i]}, {31'b0, (i % 5) == 4});

        D1_almost_full = 1'b1;
        repeat (3) cycle();
        D1_almost_full = 1'b0;
        repeat (2) cycle();

        for (int i = 0; i < 400; i++) begin
            D0_almost_full = ($urandom_range(0, 5) == 0);
            D1_almost_full = ($urandom_range(0, 5) == 0);
            init = ($urandom_range(0, 39) == 0);
            Umbral_LOW_in  = 4'($urandom_range(0, 15));
            Umbral_HIGH_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) vc0_q.push_back(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) vc1_q.push_back(6'($urandom_range(0, 63)));
            upd_empty();
            cycle();
        end
        D0_almost_full = 1'b0; D1_almost_full = 1'b0; init = 1'b0;
        for (int k = 0; k < 300 && (vc0_q.size() != 0 || vc1_q.size() != 0 || ms != M_IDLE); k++)
            cycle();
        chk("drain", {31'b0, ms == M_IDLE && vc0_q.size() == 0 && vc1_q.size() == 0}, 32'd1);

        for (int i = 0; i < 6; i++) vc0_q.push_back(6'($urandom_range(0, 63)));
        vc1_q.push_back(6'h2A);
        upd_empty();
        repeat (2) cycle();
        fifo_error = 4'b0100;
        cycle();
        fifo_error = 4'b0000;
        cycle();
        chk("err_state", {27'b0, state}, 32'b10000);
        chk("err_out", {31'b0, error_out}, 32'd1);
        init = 1'b1;
        repeat (3) cycle();
        init = 1'b0;
        cycle();
        chk("err_sticky", {27'b0, state}, 32'b10000);

        reset_L = 1'b0;
        vc0_q.delete(); vc1_q.delete(); upd_empty();
        cycle();
        reset_L = 1'b1; init = 1'b1;
        repeat (2) cycle();
        init = 1'b0;
        cycle();
        vc0_q.push_back(6'h0A); vc0_q.push_back(6'h0B); vc0_q.push_back(6'h0C);
        upd_empty();
        for (int k = 0; k < 10 && !mpend; k++) cycle();
        chk("pend_seen", {31'b0, mpend}, 32'd1);
        chk("pend_wr", {31'b0, D0_wr | D1_wr}, 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_clr", {28'b0, D0_wr, D1_wr, VC0_rd, VC1_rd}, 32'd0);
        chk("async_st", {27'b0, state}, 32'b00001);
        vc0_q.delete(); vc1_q.delete(); upd_empty();
        cycle();
        reset_L = 1'b1;
        repeat (4) cycle();
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
